// File: rtl/hd_codec_pkg.sv
// Shared constants, FSM state encoding and syndrome classification
// for the Hamming (12,8) decode arbiter.
package hd_codec_pkg;

   localparam int CW_W        = 12;
   localparam int DATA_W      = 8;
   localparam int SYN_W       = 4;
   localparam int SYN_MAX_POS = 12;

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

   typedef enum logic [1:0] {SYN_NONE, SYN_CORR, SYN_UNCORR} syn_class_e;

   // A syndrome names a 1-based bit position; anything past the last
   // codeword bit cannot come from a single error.
   function automatic syn_class_e syn_class(input logic [SYN_W-1:0] syn);
      syn_class_e cls;
      if (syn == '0)
         cls = SYN_NONE;
      else if (int'(syn) <= SYN_MAX_POS)
         cls = SYN_CORR;
      else
         cls = SYN_UNCORR;
      return cls;
   endfunction

endpackage

// File: rtl/hd_rr_arbiter.sv
// Round-robin grant over N_REQ valid lines; the search starts one past
// the last granted index, and the pointer advances only on gnt_en_i.
module hd_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] valid_i,
   input  logic             gnt_en_i,
   output logic             any_o,
   output logic [N_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]  gnt_id_o
);

   logic [ID_W-1:0] last_q;

   always_comb begin
      int              idx;
      logic [ID_W-1:0] idx_w;
      any_o    = 1'b0;
      gnt_o    = '0;
      gnt_id_o = '0;
      idx      = 0;
      idx_w    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(last_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idx_w = idx[ID_W-1:0];
         if (!any_o && valid_i[idx_w]) begin
            any_o        = 1'b1;
            gnt_o[idx_w] = 1'b1;
            gnt_id_o     = idx_w;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_q <= ID_W'(N_REQ - 1);
      else if (gnt_en_i && any_o)
         last_q <= gnt_id_o;
   end

endmodule

// File: rtl/hd_codec_arbiter.sv
// Shares one external Hamming (12,8) decoder among N_REQ requesters.
// Optional build macro HD_ARB_STATS_EN adds corrected/uncorrectable counters.
module hd_codec_arbiter
   import hd_codec_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*CW_W-1:0] req_cw,
   output logic [CW_W-1:0]       codec_cw,
   input  logic [DATA_W-1:0]     codec_data,
   input  logic [SYN_W-1:0]      codec_syn,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [DATA_W-1:0]     rsp_data,
   output logic                  rsp_corr,
   output logic                  rsp_uncorr
`ifdef HD_ARB_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [15:0]           cnt_corr,
   output logic [15:0]           cnt_uncorr
`endif
);

   state_e            state_q, state_d;
   logic              grant_en;
   logic              any_req;
   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_id;
   logic [ID_W-1:0]   id_q;
   logic [CW_W-1:0]   codec_cw_q;
   logic              rsp_valid_q, rsp_corr_q, rsp_uncorr_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_hs;
   syn_class_e        cls;

   assign rsp_hs = rsp_valid_q & rsp_ready;
   assign cls    = syn_class(codec_syn);

   hd_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (req_valid),
      .gnt_en_i (grant_en),
      .any_o    (any_req),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   // Freeing the response slot and granting the next request share one cycle.
   always_comb begin
      state_d  = state_q;
      grant_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_en = 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: state_d = HOLD;
         HOLD: begin
            if (rsp_hs) begin
               grant_en = any_req;
               state_d  = any_req ? ISSUE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready = grant_en ? gnt : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         codec_cw_q <= '0;
         id_q       <= '0;
      end else begin
         state_q <= state_d;
         if (grant_en) begin
            codec_cw_q <= req_cw[int'(gnt_id)*CW_W +: CW_W];
            id_q       <= gnt_id;
         end
      end
   end

   // The decoder settles during ISSUE, so its result is captured there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_corr_q   <= 1'b0;
         rsp_uncorr_q <= 1'b0;
      end else if (state_q == ISSUE) begin
         rsp_valid_q  <= 1'b1;
         rsp_id_q     <= id_q;
         rsp_data_q   <= codec_data;
         rsp_corr_q   <= (cls == SYN_CORR);
         rsp_uncorr_q <= (cls == SYN_UNCORR);
      end else if (rsp_hs) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign codec_cw   = codec_cw_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_corr   = rsp_corr_q;
   assign rsp_uncorr = rsp_uncorr_q;

`ifdef HD_ARB_STATS_EN
   logic [15:0] cnt_corr_q, cnt_uncorr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_corr_q   <= '0;
         cnt_uncorr_q <= '0;
      end else if (stat_clr) begin
         cnt_corr_q   <= '0;
         cnt_uncorr_q <= '0;
      end else if (rsp_hs) begin
         if (rsp_corr_q && cnt_corr_q != 16'hFFFF)
            cnt_corr_q <= cnt_corr_q + 16'd1;
         if (rsp_uncorr_q && cnt_uncorr_q != 16'hFFFF)
            cnt_uncorr_q <= cnt_uncorr_q + 16'd1;
      end
   end

   assign cnt_corr   = cnt_corr_q;
   assign cnt_uncorr = cnt_uncorr_q;
`endif

endmodule
